// File: rtl/Datapath_pkg.sv
// ----------------------------------------------------------------------------
// Datapath_pkg
// Mux-select encodings and ALU operation codes of the multi-cycle datapath.
// The select encodings match the 2-bit control fields issued by ControlFSM.
// ----------------------------------------------------------------------------
package Datapath_pkg;

    // Result mux: 2'b11 behaves like RES_ALURESULT.
    typedef enum logic [1:0] {
        RES_ALUOUT    = 2'b00,
        RES_DATA      = 2'b01,
        RES_ALURESULT = 2'b10
    } ResultSrc_t;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'b00,
        SRCA_OLDPC = 2'b01,
        SRCA_A     = 2'b10,
        SRCA_ZERO  = 2'b11
    } ALUSrcA_t;

    typedef enum logic [1:0] {
        SRCB_B    = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10,
        SRCB_ZERO = 2'b11
    } ALUSrcB_t;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } ImmSrc_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } ALUCtrl_t;

    // ALUOp field from the controller.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/OpCode_pkg.sv
// ----------------------------------------------------------------------------
// OpCode_pkg
// Shared RV32I major-opcode encodings (IR[6:0]) used by the controller and
// the multi-cycle datapath.
// ----------------------------------------------------------------------------
package OpCode_pkg;

    typedef enum logic [6:0] {
        OP_LW    = 7'b0000011,
        OP_ITYPE = 7'b0010011,
        OP_SW    = 7'b0100011,
        OP_RTYPE = 7'b0110011,
        OP_BEQ   = 7'b1100011,
        OP_JAL   = 7'b1101111
    } OpCode_t;

endpackage

// File: rtl/reg_file.sv
// ----------------------------------------------------------------------------
// reg_file
// 32 x 32-bit register file, two asynchronous read ports, one synchronous
// write port. x0 is hardwired to zero: writes to it are dropped and reads
// of it return 0. Every entry clears on reset.
//
// Ports:
//   i_Clk, i_Reset   clock, asynchronous active-high reset
//   we               write enable
//   a1, a2           read addresses        -> rd1, rd2
//   a3, wd3          write address / data
// ----------------------------------------------------------------------------
module reg_file (
    input  logic        i_Clk,
    input  logic        i_Reset,
    input  logic        we,
    input  logic [4:0]  a1,
    input  logic [4:0]  a2,
    input  logic [4:0]  a3,
    input  logic [31:0] wd3,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);

    logic [31:0] regs [32];

    // NOTE: resetting the whole array makes it plain flops rather than a RAM
    // macro; that is what lets a reset wipe every architectural register.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (a3 != 5'd0)) begin
            regs[a3] <= wd3;
        end
    end

    assign rd1 = (a1 == 5'd0) ? 32'd0 : regs[a1];
    assign rd2 = (a2 == 5'd0) ? 32'd0 : regs[a2];

endmodule

// File: rtl/mc_datapath.sv
// ----------------------------------------------------------------------------
// mc_datapath
// Multi-cycle RV32I datapath driven by the ControlFSM control word. Holds
// PC, OldPC, IR, Data, A, B, ALUOut, the register file and the ALU, and
// shares one memory port between instruction fetch and data access.
//
// Ports:
//   i_Clk, i_Reset                      clock, asynchronous active-high reset
//   i_Branch, i_PCUpdate, i_IRWrite,
//   i_MemWrite, i_RegWrite, i_AdrSrc    1-bit FSM controls
//   i_ResultSrc, i_ALUSrcA, i_ALUSrcB,
//   i_ALUOp                             2-bit FSM controls
//   i_MemRData                          memory read data (combinational)
//   o_MemAdr, o_MemWData, o_MemWE       memory address / store data / write
//   o_OpCode, o_Funct3, o_Funct7b5      IR fields back to the FSM
//   o_Zero                              ALU result == 0
//   o_PC                                current PC
// ----------------------------------------------------------------------------
module mc_datapath
    import OpCode_pkg::*;
    import Datapath_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_Clk,
    input  logic        i_Reset,
    input  logic        i_Branch,
    input  logic        i_PCUpdate,
    input  logic        i_IRWrite,
    input  logic        i_MemWrite,
    input  logic        i_RegWrite,
    input  logic        i_AdrSrc,
    input  logic [1:0]  i_ResultSrc,
    input  logic [1:0]  i_ALUSrcA,
    input  logic [1:0]  i_ALUSrcB,
    input  logic [1:0]  i_ALUOp,
    input  logic [31:0] i_MemRData,
    output logic [31:0] o_MemAdr,
    output logic [31:0] o_MemWData,
    output logic        o_MemWE,
    output logic [6:0]  o_OpCode,
    output logic [2:0]  o_Funct3,
    output logic        o_Funct7b5,
    output logic        o_Zero,
    output logic [31:0] o_PC
);

    logic [31:0] pc, old_pc, ir, data, a_reg, b_reg, alu_out;
    logic [31:0] rd1, rd2, imm_ext, src_a, src_b, alu_result, result;
    logic        pc_write;
    ImmSrc_t     imm_src;
    ALUCtrl_t    alu_ctrl;
    OpCode_t     opcode;

    assign opcode = OpCode_t'(ir[6:0]);

    // ------------------------------------------------------------------
    // Immediate select and sign extension
    // ------------------------------------------------------------------
    // NOTE: every always_comb output gets a default before the case, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        imm_src = IMM_I;
        case (opcode)
            OP_SW:   imm_src = IMM_S;
            OP_BEQ:  imm_src = IMM_B;
            OP_JAL:  imm_src = IMM_J;
            default: imm_src = IMM_I;
        endcase
    end

    always_comb begin
        imm_ext = {{20{ir[31]}}, ir[31:20]};
        case (imm_src)
            IMM_S:   imm_ext = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            IMM_B:   imm_ext = {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
            IMM_J:   imm_ext = {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
            default: imm_ext = {{20{ir[31]}}, ir[31:20]};
        endcase
    end

    // ------------------------------------------------------------------
    // ALU decode: only R-type (op[5]=1) with funct7b5 selects subtract
    // under funct3 000; I-type add never becomes sub.
    // ------------------------------------------------------------------
    always_comb begin
        alu_ctrl = ALU_ADD;
        case (i_ALUOp)
            ALUOP_ADD: alu_ctrl = ALU_ADD;
            ALUOP_SUB: alu_ctrl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (ir[14:12])
                    3'b000:  alu_ctrl = ({ir[5], ir[30]} == 2'b11) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_ctrl = ALU_SLT;
                    3'b110:  alu_ctrl = ALU_OR;
                    3'b111:  alu_ctrl = ALU_AND;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            default: alu_ctrl = ALU_ADD;
        endcase
    end

    // ------------------------------------------------------------------
    // Operand muxes, ALU, result mux
    // ------------------------------------------------------------------
    always_comb begin
        src_a = pc;
        case (ALUSrcA_t'(i_ALUSrcA))
            SRCA_PC:    src_a = pc;
            SRCA_OLDPC: src_a = old_pc;
            SRCA_A:     src_a = a_reg;
            default:    src_a = 32'd0;
        endcase
    end

    always_comb begin
        src_b = b_reg;
        case (ALUSrcB_t'(i_ALUSrcB))
            SRCB_B:    src_b = b_reg;
            SRCB_IMM:  src_b = imm_ext;
            SRCB_FOUR: src_b = 32'd4;
            default:   src_b = 32'd0;
        endcase
    end

    always_comb begin
        alu_result = src_a + src_b;
        case (alu_ctrl)
            ALU_ADD: alu_result = src_a + src_b;
            ALU_SUB: alu_result = src_a - src_b;
            ALU_AND: alu_result = src_a & src_b;
            ALU_OR:  alu_result = src_a | src_b;
            ALU_SLT: alu_result = {31'd0, $signed(src_a) < $signed(src_b)};
            default: alu_result = src_a + src_b;
        endcase
    end

    always_comb begin
        result = alu_result;
        case (ResultSrc_t'(i_ResultSrc))
            RES_ALUOUT: result = alu_out;
            RES_DATA:   result = data;
            default:    result = alu_result;
        endcase
    end

    assign o_Zero   = (alu_result == 32'd0);
    assign pc_write = i_PCUpdate | (i_Branch & o_Zero);

    // ------------------------------------------------------------------
    // Architectural and inter-state registers
    // ------------------------------------------------------------------
    // NOTE: non-blocking assignments so every register samples the values
    // present before the edge, independent of statement order.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            pc      <= RESET_PC;
            old_pc  <= '0;
            ir      <= '0;
            data    <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            alu_out <= '0;
        end else begin
            if (pc_write) begin
                pc <= result;
            end
            if (i_IRWrite) begin
                ir     <= i_MemRData;
                old_pc <= pc;
            end
            data    <= i_MemRData;
            a_reg   <= rd1;
            b_reg   <= rd2;
            alu_out <= alu_result;
        end
    end

    reg_file u_rf (
        .i_Clk   (i_Clk),
        .i_Reset (i_Reset),
        .we      (i_RegWrite),
        .a1      (ir[19:15]),
        .a2      (ir[24:20]),
        .a3      (ir[11:7]),
        .wd3     (result),
        .rd1     (rd1),
        .rd2     (rd2)
    );

    assign o_MemAdr   = i_AdrSrc ? result : pc;
    assign o_MemWData = b_reg;
    assign o_MemWE    = i_MemWrite;
    assign o_OpCode   = ir[6:0];
    assign o_Funct3   = ir[14:12];
    assign o_Funct7b5 = ir[30];
    assign o_PC       = pc;

endmodule

// File: tb/tb_mc_datapath.sv
// ----------------------------------------------------------------------------
// tb_mc_datapath
// The bench plays the controller (issuing each state's control word) and a
// 1 KB word memory (aliased on address bits [9:2]). Instructions are kept
// as symbolic records; an instruction-level model executes those records
// and its register/PC/memory state is compared with the DUT.
// ----------------------------------------------------------------------------
module tb_mc_datapath;

    typedef enum int { K_R, K_I, K_LW, K_SW, K_BEQ, K_JAL } kind_t;

    typedef struct {
        kind_t       kind;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic        f7b5;
        logic [31:0] imm;
    } ins_t;

    logic        i_Clk, i_Reset;
    logic        i_Branch, i_PCUpdate, i_IRWrite, i_MemWrite, i_RegWrite, i_AdrSrc;
    logic [1:0]  i_ResultSrc, i_ALUSrcA, i_ALUSrcB, i_ALUOp;
    logic [31:0] i_MemRData;
    logic [31:0] o_MemAdr, o_MemWData, o_PC;
    logic        o_MemWE, o_Funct7b5, o_Zero;
    logic [6:0]  o_OpCode;
    logic [2:0]  o_Funct3;

    logic [31:0] mem     [256];   // memory seen by the DUT
    logic [31:0] ref_mem [256];   // model's view of memory
    ins_t        prog    [256];   // symbolic instruction at each word
    logic [31:0] m_regs  [32];
    logic [31:0] m_pc;

    int total = 0;
    int bad   = 0;

    assign i_MemRData = mem[o_MemAdr[9:2]];

    mc_datapath #(.RESET_PC(32'h0000_0000)) dut (
        .i_Clk(i_Clk), .i_Reset(i_Reset),
        .i_Branch(i_Branch), .i_PCUpdate(i_PCUpdate), .i_IRWrite(i_IRWrite),
        .i_MemWrite(i_MemWrite), .i_RegWrite(i_RegWrite), .i_AdrSrc(i_AdrSrc),
        .i_ResultSrc(i_ResultSrc), .i_ALUSrcA(i_ALUSrcA), .i_ALUSrcB(i_ALUSrcB),
        .i_ALUOp(i_ALUOp), .i_MemRData(i_MemRData),
        .o_MemAdr(o_MemAdr), .o_MemWData(o_MemWData), .o_MemWE(o_MemWE),
        .o_OpCode(o_OpCode), .o_Funct3(o_Funct3), .o_Funct7b5(o_Funct7b5),
        .o_Zero(o_Zero), .o_PC(o_PC)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- instruction records and encodings ----------------
    function automatic ins_t mk(input kind_t k, input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [2:0] f3, input logic f7b5,
                                input logic [31:0] imm);
        ins_t r;
        r.kind = k; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.f3 = f3; r.f7b5 = f7b5; r.imm = imm;
        return r;
    endfunction

    function automatic logic [31:0] enc(input ins_t in);
        logic [31:0] im;
        im = in.imm;
        case (in.kind)
            K_R:   return {1'b0, in.f7b5, 5'd0, in.rs2, in.rs1, in.f3, in.rd, 7'b0110011};
            K_I:   return {im[11:0], in.rs1, in.f3, in.rd, 7'b0010011};
            K_LW:  return {im[11:0], in.rs1, 3'b010, in.rd, 7'b0000011};
            K_SW:  return {im[11:5], in.rs2, in.rs1, 3'b010, im[4:0], 7'b0100011};
            K_BEQ: return {im[12], im[10:5], in.rs2, in.rs1, 3'b000, im[4:1], im[11], 7'b1100011};
            default: return {im[20], im[10:1], im[11], im[19:12], in.rd, 7'b1101111};
        endcase
    endfunction

    task automatic put(input logic [31:0] addr, input ins_t in);
        prog[addr[9:2]]    = in;
        mem[addr[9:2]]     = enc(in);
        ref_mem[addr[9:2]] = enc(in);
    endtask

    // Instruction-level arithmetic: any unlisted funct3 behaves as add.
    function automatic logic [31:0] alu_ref(input logic [2:0] f3, input logic sub,
                                            input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'b000:  return sub ? a - b : a + b;
            3'b010:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'b110:  return a | b;
            3'b111:  return a & b;
            default: return a + b;
        endcase
    endfunction

    // ---------------- controller emulation ----------------
    task automatic ctl(input logic [1:0] res, input logic [1:0] sa, input logic [1:0] sb,
                       input logic [1:0] aop, input logic adr, input logic irw, input logic pcu,
                       input logic br, input logic mw, input logic rw);
        i_ResultSrc = res; i_ALUSrcA = sa; i_ALUSrcB = sb; i_ALUOp = aop;
        i_AdrSrc = adr; i_IRWrite = irw; i_PCUpdate = pcu;
        i_Branch = br; i_MemWrite = mw; i_RegWrite = rw;
        #2;
    endtask

    task automatic idle();
        i_ResultSrc = 2'b00; i_ALUSrcA = 2'b00; i_ALUSrcB = 2'b00; i_ALUOp = 2'b00;
        i_AdrSrc = 1'b0; i_IRWrite = 1'b0; i_PCUpdate = 1'b0;
        i_Branch = 1'b0; i_MemWrite = 1'b0; i_RegWrite = 1'b0;
    endtask

    // Advance one clock; the memory commits a store just after the edge.
    task automatic tick();
        logic        we_s;
        logic [31:0] adr_s, wd_s;
        we_s = o_MemWE; adr_s = o_MemAdr; wd_s = o_MemWData;
        @(posedge i_Clk);
        #1;
        if (we_s) mem[adr_s[9:2]] = wd_s;
    endtask

    task automatic st_fetch();  ctl(2'b10, 2'b00, 2'b10, 2'b00, 0, 1, 1, 0, 0, 0); endtask
    task automatic st_decode(); ctl(2'b00, 2'b01, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0); endtask
    task automatic st_exec_r(); ctl(2'b00, 2'b10, 2'b00, 2'b10, 0, 0, 0, 0, 0, 0); endtask
    task automatic st_alu_wb(); ctl(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1); endtask

    // Run one whole instruction at the model PC through its state sequence.
    task automatic run_instr();
        ins_t        in;
        logic [31:0] w, a, b, addr, res, pc0, pc_n;
        logic        zero, wr;
        pc0  = m_pc;
        in   = prog[pc0[9:2]];
        w    = enc(in);
        a    = m_regs[in.rs1];
        b    = m_regs[in.rs2];
        addr = a + in.imm;
        zero = (a == b);
        pc_n = pc0 + 32'd4;
        res  = 32'd0;
        wr   = 1'b0;
        case (in.kind)
            K_R:   begin res = alu_ref(in.f3, in.f7b5, a, b);      wr = 1'b1; end
            K_I:   begin res = alu_ref(in.f3, 1'b0, a, in.imm);    wr = 1'b1; end
            K_LW:  begin res = ref_mem[addr[9:2]];                 wr = 1'b1; end
            K_SW:  ref_mem[addr[9:2]] = b;
            K_BEQ: if (zero) pc_n = pc0 + in.imm;
            K_JAL: begin res = pc0 + 32'd4; pc_n = pc0 + in.imm;   wr = 1'b1; end
            default: ;
        endcase
        if (wr && in.rd != 5'd0) m_regs[in.rd] = res;
        m_pc = pc_n;

        st_fetch();
        check("fetch_adr", o_MemAdr, pc0);
        check("we_idle", {31'd0, o_MemWE}, 32'd0);
        tick();
        check("pc_plus4", o_PC, pc0 + 32'd4);
        st_decode();
        check("opcode", {25'd0, o_OpCode}, {25'd0, w[6:0]});
        check("funct3", {29'd0, o_Funct3}, {29'd0, w[14:12]});
        check("funct7b5", {31'd0, o_Funct7b5}, {31'd0, w[30]});
        tick();
        case (in.kind)
            K_R: begin st_exec_r(); tick(); st_alu_wb(); tick(); end
            K_I: begin ctl(2'b00, 2'b10, 2'b01, 2'b10, 0, 0, 0, 0, 0, 0); tick(); st_alu_wb(); tick(); end
            K_LW: begin
                ctl(2'b00, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0); tick();
                ctl(2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 0, 0);
                check("lw_adr", o_MemAdr, addr);
                tick();
                ctl(2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1); tick();
            end
            K_SW: begin
                ctl(2'b00, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0); tick();
                ctl(2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 1, 0);
                check("sw_we", {31'd0, o_MemWE}, 32'd1);
                check("sw_adr", o_MemAdr, addr);
                check("sw_wdata", o_MemWData, b);
                tick();
            end
            K_BEQ: begin
                ctl(2'b00, 2'b10, 2'b00, 2'b01, 0, 0, 0, 1, 0, 0);
                check("beq_zero", {31'd0, o_Zero}, {31'd0, zero});
                tick();
            end
            default: begin
                ctl(2'b00, 2'b01, 2'b10, 2'b00, 0, 0, 1, 0, 0, 0); tick();
                st_alu_wb(); tick();
            end
        endcase
        check("pc", o_PC, m_pc);
        if (wr) check("rd_val", dut.u_rf.regs[in.rd], m_regs[in.rd]);
    endtask

    logic [2:0]  f3_tab [5] = '{3'b000, 3'b010, 3'b110, 3'b111, 3'b100};
    logic [31:0] r;
    int          steps;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
            prog[i]    = mk(K_I, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 32'd0);
        end
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_pc = 32'd0;

        // ---------------- reset state ----------------
        idle();
        i_Reset = 1'b1;
        repeat (2) @(posedge i_Clk);
        #1;
        check("rst_pc", o_PC, 32'd0);
        check("rst_opcode", {25'd0, o_OpCode}, 32'd0);
        check("rst_funct3", {29'd0, o_Funct3}, 32'd0);
        check("rst_funct7b5", {31'd0, o_Funct7b5}, 32'd0);
        i_Reset = 1'b0;
        tick();
        check("idle_pc", o_PC, 32'd0);

        // ---------------- directed program ----------------
        put(32'h00, mk(K_I,   5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd5));
        put(32'h04, mk(K_I,   5'd2, 5'd0, 5'd0, 3'b000, 1'b0, 32'd7));
        put(32'h08, mk(K_R,   5'd3, 5'd1, 5'd2, 3'b000, 1'b1, 32'd0));
        put(32'h0C, mk(K_R,   5'd4, 5'd1, 5'd2, 3'b010, 1'b0, 32'd0));
        put(32'h10, mk(K_BEQ, 5'd0, 5'd1, 5'd1, 3'b000, 1'b0, -32'sd8));
        put(32'h14, mk(K_R,   5'd0, 5'd1, 5'd2, 3'b000, 1'b0, 32'd0));
        put(32'h18, mk(K_SW,  5'd0, 5'd0, 5'd1, 3'b010, 1'b0, 32'd8));
        put(32'h1C, mk(K_LW,  5'd5, 5'd0, 5'd0, 3'b010, 1'b0, 32'd8));
        put(32'h20, mk(K_JAL, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd16));
        check("addi_word", mem[0], 32'h0050_0093);

        run_instr(); check("addi_x1", dut.u_rf.regs[1], 32'd5);
        run_instr(); check("addi_x2", dut.u_rf.regs[2], 32'd7);
        run_instr(); check("sub_x3", dut.u_rf.regs[3], 32'hFFFF_FFFE);
        run_instr(); check("slt_x4", dut.u_rf.regs[4], 32'd1);
        run_instr(); check("beq_taken_pc", o_PC, 32'h08);
        run_instr();
        run_instr();
        put(32'h10, mk(K_BEQ, 5'd0, 5'd1, 5'd2, 3'b000, 1'b0, -32'sd8));
        run_instr(); check("beq_not_taken_pc", o_PC, 32'h14);
        run_instr(); check("x0_stays_0", dut.u_rf.regs[0], 32'd0);
        run_instr(); check("sw_mem", mem[2], 32'd5);
        run_instr(); check("lw_x5", dut.u_rf.regs[5], 32'd5);
        run_instr(); check("jal_pc", o_PC, 32'h30); check("jal_x1", dut.u_rf.regs[1], 32'h24);

        // ---------------- random program 0x30..0x1DC ----------------
        for (int ad = 32'h30; ad < 32'h1E0; ad += 4) begin
            r = $urandom;
            case ($urandom_range(0, 9))
                0, 1, 2, 3: put(ad, mk(K_R, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                                       5'($urandom_range(0, 7)), f3_tab[$urandom_range(0, 4)],
                                       1'($urandom_range(0, 1)), 32'd0));
                4, 5: put(ad, mk(K_I, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'd0,
                                 f3_tab[$urandom_range(0, 4)], 1'b0, {{20{r[11]}}, r[11:0]}));
                6: put(ad, mk(K_LW, 5'($urandom_range(1, 7)), 5'd0, 5'd0, 3'b010, 1'b0,
                              32'h200 + 32'($urandom_range(0, 127)) * 4));
                7: put(ad, mk(K_SW, 5'd0, 5'd0, 5'($urandom_range(0, 7)), 3'b010, 1'b0,
                              32'h200 + 32'($urandom_range(0, 127)) * 4));
                8: put(ad, mk(K_BEQ, 5'd0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                              3'b000, 1'b0, 32'd8));
                default: put(ad, mk(K_JAL, 5'($urandom_range(0, 7)), 5'd0, 5'd0, 3'b000, 1'b0, 32'd8));
            endcase
        end
        steps = 0;
        while (m_pc >= 32'h30 && m_pc < 32'h1E0 && steps < 500) begin
            run_instr();
            steps++;
        end
        for (int i = 0; i < 32; i++) check("rf_sweep", dut.u_rf.regs[i], m_regs[i]);

        // ---------------- reset mid-instruction ----------------
        put(m_pc, mk(K_I, 5'd3, 5'd0, 5'd0, 3'b000, 1'b0, 32'h123));
        run_instr(); check("x3_loaded", dut.u_rf.regs[3], 32'h123);
        put(m_pc, mk(K_R, 5'd3, 5'd1, 5'd2, 3'b000, 1'b0, 32'd0));
        st_fetch();  tick();
        st_decode(); tick();
        st_exec_r();
        #1 i_Reset = 1'b1;
        #1;
        check("mid_rst_pc", o_PC, 32'd0);
        check("mid_rst_opcode", {25'd0, o_OpCode}, 32'd0);
        st_alu_wb(); tick();
        idle();
        i_Reset = 1'b0;
        tick();
        check("post_rst_pc", o_PC, 32'd0);
        check("post_rst_x3", dut.u_rf.regs[3], 32'd0);
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 32'd0;
            check("post_rst_rf", dut.u_rf.regs[i], 32'd0);
        end
        m_pc = 32'd0;

        // ---------------- PC wrap 0xFFFF_FFFC + 4 -> 0 ----------------
        put(32'h000, mk(K_BEQ, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, -32'sd4));
        put(32'h3FC, mk(K_I, 5'd6, 5'd0, 5'd0, 3'b000, 1'b0, 32'd1));
        run_instr(); check("wrap_target", o_PC, 32'hFFFF_FFFC);
        run_instr(); check("wrap_pc", o_PC, 32'd0); check("wrap_x6", dut.u_rf.regs[6], 32'd1);
        put(32'h000, mk(K_I, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd5));
        run_instr(); check("post_wrap_x1", dut.u_rf.regs[1], 32'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
